mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencing arbiter that shares one single-ported backing memory between the instruction-fetch stage (port I, read-only) and the memory-access stage (port D, read/write) of the 5-stage pipeline. It serializes requests, drives the memory port for a fixed access latency and returns a one-cycle acknowledge with read data to the winning requester. Port D has fixed priority, bounded by a streak limit so that fetch cannot starve. The pipeline stalls any stage whose request is pending without ack.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles from memory sampling m_en to m_rdata valid (≥1)
- MAX_D_STREAK, 4, max consecutive D grants while i_req is held (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  AW  fetch address
- i_ack  out  1  one-cycle completion pulse for I
- i_rdata  out  DW  fetch data, valid when i_ack=1
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1=write, 0=read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ack  out  1  one-cycle completion pulse for D
- d_rdata  out  DW  read data, valid when d_ack=1 and the access was a read
- m_en  out  1  memory access strobe, one cycle per access
- m_we  out  1  memory write enable, qualified by m_en
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid MEM_LAT cycles after m_en

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: decision on each clock edge. Any request present -> latch owner, addr, we, wdata; go to ISSUE. No request -> stay.
- Grant rule:
  - D wins when d_req=1, unless streak==MAX_D_STREAK and i_req=1.
  - Otherwise I wins when i_req=1.
- Streak counter: +1 when D is granted while i_req=1. Cleared when I is granted, or at any decision with i_req=0. Saturates at MAX_D_STREAK.
- ISSUE: m_en=1 for exactly one cycle. m_we=latched we if owner is D, else 0. m_addr/m_wdata come from the latch. Go to WAIT with lat_cnt=MAX(MEM_LAT-1, 0).
- WAIT: decrement lat_cnt. When lat_cnt==0, capture m_rdata into the owner's rdata register and go to DONE.
- DONE: owner's ack=1 for one cycle; return to IDLE.
  - The IDLE decision happens in the cycle after DONE. A req still high after ack is a new request.
  - rdata holds its value until the next capture for that port.
- Write ack: after the same latency. d_rdata is not updated on writes.
- Inputs are ignored outside IDLE. The latched values drive the memory, so requester changes mid-access have no effect.
- Never grants both ports. Never issues m_en while an access is outstanding.

## Timing
- Reset values: i_ack=d_ack=0, m_en=m_we=0, m_addr=m_wdata=0, i_rdata=d_rdata=0, state=IDLE, streak=0.
- Single access with req sampled at edge E0:
  - m_en high in cycle E0+1.
  - m_rdata sampled at edge E0+1+MEM_LAT.
  - ack high during cycle E0+2+MEM_LAT.
- Request-to-ack latency is MEM_LAT+2 cycles (3 for MEM_LAT=1).
- Back-to-back throughput is one access per MEM_LAT+3 cycles, including the IDLE decision cycle.
- Simultaneous i_req and d_req at a decision: D wins unless the streak limit is reached.
- Reset asserted mid-access (ISSUE/WAIT/DONE):
  - Next cycle is IDLE with all outputs at reset values.
  - The in-flight access is dropped with no ack.
  - m_en is not reissued.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Single fetch, MEM_LAT=1:
  - Stimulus: i_req=1, i_addr=0x10, memory returns 0x8C220004.
  - Required: m_en=1 with m_addr=0x10 one cycle after the req edge; i_ack=1 with i_rdata=0x8C220004 three cycles after the req edge; d_ack stays 0.
- Data write:
  - Stimulus: d_req=1, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF.
  - Required: one m_en cycle with m_we=1, m_addr=0x20, m_wdata=0xDEADBEEF; d_ack after 3 cycles; d_rdata unchanged.
- Simultaneous requests:
  - Stimulus: i_req and d_req rise together and are held.
  - Required: D is granted first; I is granted on the next decision after D's ack once d_req is dropped.
- Starvation guard, MAX_D_STREAK=4:
  - Stimulus: d_req and i_req held continuously.
  - Required: grant order D,D,D,D,I,D,D,D,D,I; exactly one m_en per access.
- Latency parameter, MEM_LAT=3:
  - Stimulus: d_req read of 0x40, memory data 0x12345678 valid 3 cycles after m_en.
  - Required: d_ack 5 cycles after the req edge with d_rdata=0x12345678.
- Reset mid-operation:
  - Stimulus: assert rst in the WAIT cycle of a fetch.
  - Required: no i_ack; all outputs 0 the next cycle; a new i_req after rst deasserts completes normally with latency 3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets the fetch port (I) and the data port (D) share one
// single-ported memory. Accesses are serialized; D has fixed priority, but a
// run of D grants is limited so a waiting fetch cannot be starved.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MEM_LAT      = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam int LCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW  = $clog2(MAX_D_STREAK + 1);

    localparam logic [LCW-1:0] LAT_INIT   = LCW'(MEM_LAT - 1);
    localparam logic [LCW-1:0] LAT_ONE    = LCW'(1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [SW-1:0]  STREAK_ONE = SW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_owner_d;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [LCW-1:0]  r_lat_cnt;
    logic [SW-1:0]   r_streak;

    logic            r_i_ack;
    logic            r_d_ack;
    logic [DW-1:0]   r_i_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            r_m_en;
    logic            r_m_we;

    logic            w_streak_full;
    logic            w_grant_d;
    logic            w_grant_i;
    logic            w_decide;
    logic            w_capture;

    logic            w_m_en_nxt;
    logic            w_m_we_nxt;
    logic            w_i_ack_nxt;
    logic            w_d_ack_nxt;

    // Grant selection: D wins unless it has used up its streak while I waits
    always_comb begin
        w_streak_full = (r_streak == STREAK_MAX);
        w_grant_d     = d_req && !(w_streak_full && i_req);
        w_grant_i     = i_req && !w_grant_d;
        w_decide      = (r_state == S_IDLE) && (w_grant_d || w_grant_i);
        w_capture     = (r_state == S_WAIT) && (r_lat_cnt == '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_decide) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_capture) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Next values for the registered outputs
    always_comb begin
        w_m_en_nxt  = (w_next == S_ISSUE);
        w_m_we_nxt  = w_decide && w_grant_d && d_we;
        w_i_ack_nxt = w_capture && !r_owner_d;
        w_d_ack_nxt = w_capture && r_owner_d;
    end

    // Request latch, latency countdown and D streak tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_lat_cnt <= '0;
            r_streak  <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                // A D grant with I waiting only happens below the limit,
                // so the increment never passes STREAK_MAX.
                if (!i_req || w_grant_i) begin
                    r_streak <= '0;
                end else if (w_grant_d) begin
                    r_streak <= r_streak + STREAK_ONE;
                end
                if (w_decide) begin
                    r_owner_d <= w_grant_d;
                    r_we      <= w_grant_d && d_we;
                    r_addr    <= w_grant_d ? d_addr : i_addr;
                    r_wdata   <= w_grant_d ? d_wdata : '0;
                end
            end
            if (r_state == S_ISSUE) begin
                r_lat_cnt <= LAT_INIT;
            end else if ((r_state == S_WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - LAT_ONE;
            end
        end
    end

    // Output registers: strobes, acks and per-port read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_m_en  <= w_m_en_nxt;
            r_m_we  <= w_m_we_nxt;
            r_i_ack <= w_i_ack_nxt;
            r_d_ack <= w_d_ack_nxt;
            if (w_capture && !r_owner_d) begin
                r_i_rdata <= m_rdata;
            end
            if (w_capture && r_owner_d && !r_we) begin
                r_d_rdata <= m_rdata;
            end
        end
    end

    assign i_ack   = r_i_ack;
    assign d_ack   = r_d_ack;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign m_en    = r_m_en;
    assign m_we    = r_m_we;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic
// on a MEM_LAT=1 instance, and a latency scenario on a MEM_LAT=3 instance.
module tb_mem_port_arbiter;

    localparam int LAT = 1;
    localparam int MDS = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_req, i_ack, d_req, d_we, d_ack, m_en, m_we;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] m_addr, m_wdata, m_rdata;

    logic        l3_i_req, l3_i_ack, l3_d_req, l3_d_we, l3_d_ack, l3_m_en, l3_m_we;
    logic [31:0] l3_i_addr, l3_i_rdata, l3_d_addr, l3_d_wdata, l3_d_rdata;
    logic [31:0] l3_m_addr, l3_m_wdata, l3_m_rdata;
    logic [31:0] l3_pipe [3];

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .MAX_D_STREAK(MDS)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_D_STREAK(MDS)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_req(l3_i_req), .i_addr(l3_i_addr), .i_ack(l3_i_ack), .i_rdata(l3_i_rdata),
        .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata),
        .d_ack(l3_d_ack), .d_rdata(l3_d_rdata),
        .m_en(l3_m_en), .m_we(l3_m_we), .m_addr(l3_m_addr), .m_wdata(l3_m_wdata),
        .m_rdata(l3_m_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Initial memory contents (shared definition for the memory and the model)
    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a == 32'h10) return 32'h8C22_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // ---------------- memory emulation (MEM_LAT=1 instance) ----------------
    logic [31:0] emu_mem [logic [31:0]];

    function automatic logic [31:0] emu_rd(input logic [31:0] a);
        if (emu_mem.exists(a)) return emu_mem[a];
        return init_val(a);
    endfunction

    always @(posedge clk) begin
        if (m_en && m_we) emu_mem[m_addr] = m_wdata;
        if (m_en && !m_we) m_rdata <= emu_rd(m_addr);
        else               m_rdata <= $urandom;
    end

    // ---------------- memory emulation (MEM_LAT=3 instance) ----------------
    always @(posedge clk) begin
        if (l3_m_en && !l3_m_we)
            l3_pipe[0] <= (l3_m_addr == 32'h40) ? 32'h1234_5678 : init_val(l3_m_addr);
        else
            l3_pipe[0] <= $urandom;
        l3_pipe[1] <= l3_pipe[0];
        l3_pipe[2] <= l3_pipe[1];
    end
    assign l3_m_rdata = l3_pipe[2];

    // ---------------- transaction-level reference model ----------------
    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; int cyc; } mexp_t;
    typedef struct { logic [31:0] data; int cyc; } aexp_t;

    mexp_t       exp_m[$];
    aexp_t       exp_i[$];
    aexp_t       exp_d[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_d = '0;
    int          cyc = 0;
    int          free_at = 0;
    int          streak = 0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    // Each granted access: m_en in the cycle after the decision, ack MEM_LAT+2
    // cycles after it, next decision MEM_LAT+3 cycles after it.
    always @(posedge clk) begin
        mexp_t m;
        aexp_t a;
        cyc++;
        if (rst) begin
            exp_m.delete(); exp_i.delete(); exp_d.delete();
            free_at = cyc + 1;
            streak  = 0;
            last_d  = '0;
        end else if (cyc >= free_at) begin
            if (!i_req) streak = 0;
            if (d_req && !(i_req && streak == MDS)) begin
                if (i_req) streak++;
                m.addr = d_addr; m.we = d_we; m.wdata = d_wdata; m.cyc = cyc;
                if (d_we) ref_mem[d_addr] = d_wdata;
                else      last_d = ref_rd(d_addr);
                a.data = last_d; a.cyc = cyc + LAT + 1;
                exp_m.push_back(m); exp_d.push_back(a);
                free_at = cyc + LAT + 3;
            end else if (i_req) begin
                streak = 0;
                m.addr = i_addr; m.we = 1'b0; m.wdata = '0; m.cyc = cyc;
                a.data = ref_rd(i_addr); a.cyc = cyc + LAT + 1;
                exp_m.push_back(m); exp_i.push_back(a);
                free_at = cyc + LAT + 3;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit i_seen = 0;
    bit d_seen = 0;
    int ack_log[$];
    int men_cnt = 0;

    always @(negedge clk) begin
        mexp_t m;
        aexp_t a;
        if (m_en) begin
            men_cnt++;
            if (exp_m.size() == 0) chk("m_en_unexpected", 32'(m_en), 0);
            else begin
                m = exp_m.pop_front();
                chk("m_addr", m_addr, m.addr);
                chk("m_we", 32'(m_we), 32'(m.we));
                if (m.we) chk("m_wdata", m_wdata, m.wdata);
                chk("m_en_cycle", cyc, m.cyc);
            end
        end
        if (i_ack && d_ack) chk("both_ack", 32'(i_ack & d_ack), 0);
        if (i_ack) begin
            i_seen = 1;
            ack_log.push_back(0);
            if (exp_i.size() == 0) chk("i_ack_unexpected", 32'(i_ack), 0);
            else begin
                a = exp_i.pop_front();
                chk("i_rdata", i_rdata, a.data);
                chk("i_ack_cycle", cyc, a.cyc);
            end
        end
        if (d_ack) begin
            d_seen = 1;
            ack_log.push_back(1);
            if (exp_d.size() == 0) chk("d_ack_unexpected", 32'(d_ack), 0);
            else begin
                a = exp_d.pop_front();
                chk("d_rdata", d_rdata, a.data);
                chk("d_ack_cycle", cyc, a.cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] rnd_addr();
        return {27'd0, 3'($urandom_range(0, 7)), 2'b00};
    endfunction

    task automatic drive_step(input bit allow_new);
        if (i_req && i_seen) begin
            i_seen = 0;
            if (allow_new && $urandom_range(0, 1) == 1) i_addr = rnd_addr();
            else i_req = 1'b0;
        end else if (!i_req && allow_new && $urandom_range(0, 2) == 0) begin
            i_req = 1'b1; i_addr = rnd_addr();
        end
        if (d_req && d_seen) begin
            d_seen = 0;
            if (allow_new && $urandom_range(0, 1) == 1) begin
                d_addr = rnd_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            end else d_req = 1'b0;
        end else if (!d_req && allow_new && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_addr = rnd_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
        end
    endtask

    // One isolated access with fixed-latency checks; E0 is the req edge.
    task automatic run_single(input bit is_d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rd);
        @(posedge clk); #1;
        if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
        else begin i_req = 1'b1; i_addr = addr; end
        @(posedge clk);
        @(negedge clk);
        chk("single_m_en", 32'(m_en), 1);
        chk("single_m_we", 32'(m_we), 32'(is_d & we));
        chk("single_m_addr", m_addr, addr);
        if (is_d && we) chk("single_m_wdata", m_wdata, wdata);
        @(negedge clk);
        chk("single_no_early_ack", 32'(i_ack | d_ack), 0);
        @(negedge clk);
        chk("single_ack", 32'(is_d ? d_ack : i_ack), 1);
        chk("single_other_ack", 32'(is_d ? i_ack : d_ack), 0);
        chk("single_rdata", is_d ? d_rdata : i_rdata, exp_rd);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ack_at;
        int men0;
        int pat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        rst = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        l3_i_req = 1'b0; l3_i_addr = '0; l3_d_req = 1'b0; l3_d_we = 1'b0;
        l3_d_addr = '0; l3_d_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_ack", 32'(i_ack), 0);
        chk("rst_d_ack", 32'(d_ack), 0);
        chk("rst_m_en", 32'(m_en), 0);
        chk("rst_m_we", 32'(m_we), 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single fetch, then data write leaving d_rdata untouched
        run_single(1'b0, 1'b0, 32'h10, 32'h0, 32'h8C22_0004);
        run_single(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0);

        // simultaneous requests: D first, I after d_req drops
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h34; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        @(posedge clk);
        @(negedge clk);
        chk("sim_first_addr", m_addr, 32'h30);
        @(negedge clk); @(negedge clk);
        chk("sim_d_ack", 32'(d_ack), 1);
        chk("sim_d_rdata", d_rdata, init_val(32'h30));
        @(posedge clk); #1;
        d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("sim_second_addr", m_addr, 32'h34);
        @(negedge clk); @(negedge clk);
        chk("sim_i_ack", 32'(i_ack), 1);
        @(posedge clk); #1;
        i_req = 1'b0;

        // starvation guard: both held continuously
        @(posedge clk); #1;
        ack_log.delete();
        men0 = men_cnt;
        i_req = 1'b1; i_addr = 32'h54; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
        for (int k = 0; k < 120 && ack_log.size() < 10; k++) @(negedge clk);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        chk("starve_ack_count", ack_log.size(), 10);
        for (int k = 0; k < 10 && k < ack_log.size(); k++)
            chk($sformatf("starve_order_%0d", k), ack_log[k], pat[k]);
        chk("starve_m_en_count", men_cnt - men0, 10);

        // randomized traffic
        repeat (2) @(posedge clk);
        i_seen = 0; d_seen = 0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            drive_step(1'b1);
        end
        for (int c = 0; c < 300 && (i_req || d_req); c++) begin
            @(posedge clk); #1;
            drive_step(1'b0);
        end
        chk("drain_done", 32'(i_req | d_req), 0);
        repeat (4) @(posedge clk);
        chk("exp_m_empty", exp_m.size(), 0);
        chk("exp_i_empty", exp_i.size(), 0);
        chk("exp_d_empty", exp_d.size(), 0);

        // reset asserted during the WAIT cycle of a fetch
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h10;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_i_ack", 32'(i_ack), 0);
        chk("mid_rst_d_ack", 32'(d_ack), 0);
        chk("mid_rst_m_en", 32'(m_en), 0);
        chk("mid_rst_m_we", 32'(m_we), 0);
        chk("mid_rst_m_addr", m_addr, 0);
        chk("mid_rst_m_wdata", m_wdata, 0);
        chk("mid_rst_i_rdata", i_rdata, 0);
        chk("mid_rst_d_rdata", d_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_ack", 32'(i_ack), 0);
            chk("post_rst_no_m_en", 32'(m_en), 0);
        end
        run_single(1'b0, 1'b0, 32'h14, 32'h0, ref_rd(32'h14));

        // MEM_LAT=3 instance: D read of 0x40
        @(posedge clk); #1;
        l3_d_req = 1'b1; l3_d_we = 1'b0; l3_d_addr = 32'h40;
        @(posedge clk);
        ack_at = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("l3_m_en", 32'(l3_m_en), 1);
                chk("l3_m_addr", l3_m_addr, 32'h40);
            end
            if (l3_d_ack) begin
                ack_at = k;
                chk("l3_d_rdata", l3_d_rdata, 32'h1234_5678);
                break;
            end
        end
        chk("l3_ack_cycle", ack_at, 4);
        @(posedge clk); #1;
        l3_d_req = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
